// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: queued command master driving an AHB-Lite slave.
// Issues single NONSEQ transfers with pipelined address/data phases.
//
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   cmd_valid/cmd_ready   command push handshake (write, addr, wdata)
//   rsp_valid/rsp_data    one-cycle read response, data held
//   HADDR/HWRITE/HTRANS   address phase, driven from the FIFO head
//   HWDATA/HRDATA/HREADY  data phase
//   busy                  queued work or data phase outstanding
//   wr_count/rd_count     completed transfer counters (wrapping)
module ahb_cmd_master #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t        mem [DEPTH];
  cmd_t        head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;

  logic              dp_valid;
  logic              dp_write;
  logic [DATA_W-1:0] dp_wdata;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic dp_done;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  // Ready depends only on registered occupancy, so a pop in the
  // same cycle never opens a slot for a full FIFO.
  assign cmd_ready = HRESETn & ~full;
  assign push    = cmd_valid & cmd_ready;
  assign pop     = ~empty & HREADY;
  assign dp_done = dp_valid & HREADY;
  assign head    = mem[rptr];

  assign HTRANS = empty ? 2'b00 : 2'b10;
  assign HADDR  = empty ? '0 : head.addr;
  assign HWRITE = ~empty & head.write;
  assign HWDATA = (dp_valid & dp_write) ? dp_wdata : '0;
  assign busy   = ~empty | dp_valid;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wptr] <= '{write: cmd_write,
                     addr:  cmd_addr,
                     wdata: cmd_wdata};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (HREADY) begin
      dp_valid <= pop;
      if (pop) begin
        dp_write <= head.write;
        dp_wdata <= head.wdata;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      rsp_valid <= dp_done & ~dp_write;
      if (dp_done & dp_write) begin
        wr_count <= wr_count + 1'b1;
      end
      if (dp_done & ~dp_write) begin
        rsp_data <= HRDATA;
        rd_count <= rd_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed vectors plus randomized traffic
// checked against a queue-level transaction model and SRAM slave.
module tb_ahb_cmd_master;

  localparam int AW = 21;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] HRDATA = '0;
  logic          HREADY = 1'b1;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA;
  logic          busy;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;

  ahb_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int passed = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  n, act, exp, $time);
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  // transaction-level reference: queue of commands, one data slot
  cmd_t          mq[$];
  cmd_t          mdp;
  bit            mdpv;
  bit            m_rsp_v;
  logic [DW-1:0] m_rsp_d;
  int            m_wr;
  int            m_rd;
  logic [DW-1:0] rmem [16];

  // SRAM-backed slave
  logic [DW-1:0] smem [16];
  bit            sdp_valid;
  bit            sdp_write;
  logic [AW-1:0] sdp_addr;

  logic [1:0]    cap_trans;
  logic [AW-1:0] cap_addr;
  logic          cap_write;
  logic [DW-1:0] cap_wdata;

  bit model_on = 1;
  bit auto_rdata = 1;
  int run = 0;
  int max_run = 0;
  int ncyc = 0;
  int acc_n = 0;
  logic [DW-1:0] rsp_q[$];
  int rsp_cyc[$];

  task automatic clear_all();
    mq.delete();
    mdpv = 0;
    m_rsp_v = 0;
    m_rsp_d = '0;
    m_wr = 0;
    m_rd = 0;
    sdp_valid = 0;
    sdp_write = 0;
    sdp_addr = '0;
    for (int i = 0; i < 16; i++) begin
      rmem[i] = '0;
      smem[i] = '0;
    end
  endtask

  task automatic model_step();
    bit rdy;
    rdy = mq.size() < DEPTH;
    m_rsp_v = 0;
    if (HREADY) begin
      if (mdpv) begin
        if (mdp.w) begin
          rmem[mdp.a[3:0]] = mdp.d;
          m_wr++;
        end else begin
          m_rsp_v = 1;
          m_rsp_d = rmem[mdp.a[3:0]];
          m_rd++;
        end
      end
      mdpv = 0;
      if (mq.size() > 0) begin
        mdp = mq.pop_front();
        mdpv = 1;
      end
    end
    if (cmd_valid && rdy) mq.push_back('{cmd_write, cmd_addr, cmd_wdata});
  endtask

  task automatic model_check();
    cmd_t h;
    bit hv;
    hv = mq.size() > 0;
    h = '{1'b0, '0, '0};
    if (hv) h = mq[0];
    chk("htrans", 32'(HTRANS), hv ? 32'h2 : 32'h0);
    chk("haddr", 32'(HADDR), 32'(h.a));
    chk("hwrite", 32'(HWRITE), 32'(h.w));
    chk("hwdata", 32'(HWDATA),
        (mdpv && mdp.w) ? 32'(mdp.d) : 32'h0);
    chk("cmd_ready", 32'(cmd_ready),
        32'(HRESETn && (mq.size() < DEPTH)));
    chk("busy", 32'(busy), 32'(hv || mdpv));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
    chk("wr_count", 32'(wr_count), 32'(m_wr[CW-1:0]));
    chk("rd_count", 32'(rd_count), 32'(m_rd[CW-1:0]));
  endtask

  // one clock: drive slave data, check at negedge, advance at posedge
  task automatic cyc();
    if (auto_rdata) begin
      HRDATA = (sdp_valid && !sdp_write) ? smem[sdp_addr[3:0]]
                                         : DW'($urandom);
    end
    @(negedge HCLK);
    cap_trans = HTRANS;
    cap_addr = HADDR;
    cap_write = HWRITE;
    cap_wdata = HWDATA;
    if (HTRANS == 2'b10) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (rsp_valid) begin
      rsp_q.push_back(rsp_data);
      rsp_cyc.push_back(ncyc);
    end
    if (cmd_valid && cmd_ready) acc_n++;
    ncyc++;
    if (model_on) model_check();
    @(posedge HCLK);
    if (!HRESETn) begin
      clear_all();
    end else begin
      if (HREADY) begin
        if (sdp_valid && sdp_write) smem[sdp_addr[3:0]] = cap_wdata;
        sdp_valid = (cap_trans == 2'b10);
        sdp_addr = cap_addr;
        sdp_write = cap_write;
      end
      if (model_on) model_step();
    end
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 0;
    cmd_valid = 1;
    cmd_write = 1;
    cmd_addr = AW'(7);
    cmd_wdata = 8'hEE;
    HREADY = 1;
    model_on = 1;
    auto_rdata = 1;
    clear_all();
    repeat (2) cyc();
    HRESETn = 1;
    cmd_valid = 0;
  endtask

  typedef struct {
    logic          v;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rdy;
    logic [DW-1:0] rdat;
    logic [1:0]    e_trans;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [DW-1:0] e_wdata;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic [CW-1:0] e_wc;
    logic [CW-1:0] e_rc;
  } vec_t;

  vec_t tv [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single write, then read with two wait states followed by write
    tv[0] = '{1, 1, 3, 8'hA5, 1, 8'h00, 2'b00, 0, 0, 8'h00, 0, 8'h00, 0, 0};
    tv[1] = '{0, 0, 0, 8'h00, 1, 8'h00, 2'b10, 3, 1, 8'h00, 0, 8'h00, 0, 0};
    tv[2] = '{1, 0, 2, 8'h00, 1, 8'h00, 2'b00, 0, 0, 8'hA5, 0, 8'h00, 0, 0};
    tv[3] = '{1, 1, 4, 8'h5A, 1, 8'h00, 2'b10, 2, 0, 8'h00, 0, 8'h00, 1, 0};
    tv[4] = '{0, 0, 0, 8'h00, 0, 8'h77, 2'b10, 4, 1, 8'h00, 0, 8'h00, 1, 0};
    tv[5] = '{0, 0, 0, 8'h00, 0, 8'h66, 2'b10, 4, 1, 8'h00, 0, 8'h00, 1, 0};
    tv[6] = '{0, 0, 0, 8'h00, 1, 8'hC3, 2'b10, 4, 1, 8'h00, 0, 8'h00, 1, 0};
    tv[7] = '{0, 0, 0, 8'h00, 1, 8'h00, 2'b00, 0, 0, 8'h5A, 1, 8'hC3, 1, 1};
    tv[8] = '{0, 0, 0, 8'h00, 1, 8'h00, 2'b00, 0, 0, 8'h00, 0, 8'hC3, 2, 1};

    #1;
    do_reset();
    repeat (2) cyc();

    model_on = 0;
    auto_rdata = 0;
    for (int i = 0; i < 9; i++) begin
      cmd_valid = tv[i].v;
      cmd_write = tv[i].w;
      cmd_addr = tv[i].a;
      cmd_wdata = tv[i].d;
      HREADY = tv[i].rdy;
      HRDATA = tv[i].rdat;
      @(negedge HCLK);
      chk($sformatf("vec%0d_htrans", i), 32'(HTRANS), 32'(tv[i].e_trans));
      chk($sformatf("vec%0d_haddr", i), 32'(HADDR), 32'(tv[i].e_addr));
      chk($sformatf("vec%0d_hwrite", i), 32'(HWRITE), 32'(tv[i].e_write));
      chk($sformatf("vec%0d_hwdata", i), 32'(HWDATA), 32'(tv[i].e_wdata));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_rv));
      chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(tv[i].e_rd));
      chk($sformatf("vec%0d_wr_count", i), 32'(wr_count), 32'(tv[i].e_wc));
      chk($sformatf("vec%0d_rd_count", i), 32'(rd_count), 32'(tv[i].e_rc));
      @(posedge HCLK);
      #1;
    end

    // back-to-back writes then reads through the SRAM slave
    do_reset();
    run = 0;
    max_run = 0;
    rsp_q.delete();
    rsp_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1;
      cmd_write = (i < 4);
      cmd_addr = AW'(i % 4);
      cmd_wdata = DW'(8'h11 * (i % 4 + 1));
      cyc();
    end
    cmd_valid = 0;
    repeat (4) cyc();
    chk("b2b_nonseq_run", 32'(max_run), 32'd8);
    chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd4);
    if (rsp_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b_rsp%0d", k), 32'(rsp_q[k]),
            32'(8'h11 * (k + 1)));
        chk($sformatf("b2b_rsp%0d_cycle", k),
            32'(rsp_cyc[k] - rsp_cyc[0]), 32'(k));
      end
    end
    chk("b2b_wr_count", 32'(wr_count), 32'd4);
    chk("b2b_rd_count", 32'(rd_count), 32'd4);

    // FIFO full under a stalled slave
    do_reset();
    HREADY = 0;
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1;
      cmd_write = 1;
      cmd_addr = AW'(8 + i);
      cmd_wdata = DW'(8'h60 + i);
      cyc();
    end
    chk("full_accepted", 32'(acc_n), 32'd4);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 0;
    HREADY = 1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_ready%0d", k), 32'(cmd_ready), 32'd1);
      cyc();
    end
    chk("drain_wr_count", 32'(wr_count), 32'd4);
    chk("drain_busy", 32'(busy), 32'd0);

    // reset while commands are queued and a read is in data phase
    do_reset();
    cmd_valid = 1;
    cmd_write = 0;
    cmd_addr = AW'(1);
    cyc();
    cmd_write = 1;
    cmd_addr = AW'(2);
    cmd_wdata = 8'h21;
    cyc();
    HREADY = 0;
    cmd_addr = AW'(3);
    cyc();
    cmd_addr = AW'(5);
    cyc();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rsp_q.delete();
    HRESETn = 0;
    cmd_valid = 0;
    HREADY = 1;
    clear_all();
    repeat (2) cyc();
    HRESETn = 1;
    repeat (4) cyc();
    chk("mid_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("mid_wr_count", 32'(wr_count), 32'd0);
    chk("mid_rd_count", 32'(rd_count), 32'd0);
    chk("mid_htrans", 32'(HTRANS), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = AW'($urandom_range(0, 15));
      cmd_wdata = DW'($urandom);
      HREADY = ($urandom_range(0, 3) != 0);
      cyc();
    end
    cmd_valid = 0;
    HREADY = 1;
    repeat (8) cyc();
    chk("rand_busy", 32'(busy), 32'd0);
    chk("rand_wr_total", 32'(wr_count), 32'(m_wr[CW-1:0]));
    chk("rand_rd_total", 32'(rd_count), 32'(m_rd[CW-1:0]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
